// File: rtl/fp_sched_pkg.sv
// Shared types for the fp_addsub scheduler: in-flight tag layout and op encoding.
package fp_sched_pkg;

  localparam int TAG_ID_W = 3;  // sized for the largest supported requester count (8)

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from an internal pointer, pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         adv,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   pos;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (en && !found && req[pos[PW-1:0]]) begin
        gnt[pos[PW-1:0]] = 1'b1;
        gnt_idx          = pos[PW-1:0];
        found            = 1'b1;
      end
    end
  end

  // wrap is explicit so non-power-of-two N works
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv && found) begin
      if (gnt_idx == PW'(N-1)) ptr <= '0;
      else                     ptr <= gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fp_addsub_sched.sv
// Shares one pipelined fp_addsub between NUM_REQ requesters; a tag pipeline routes results back.
module fp_addsub_sched
  import fp_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_addsub_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  output logic                      fpu_addsub_o,
  output logic [DATA_W-1:0]         fpu_a_o,
  output logic [DATA_W-1:0]         fpu_b_o,
  input  logic [DATA_W-1:0]         fpu_result_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_result_o,
  output logic                      busy_o
);

  logic [NUM_REQ-1:0]  gnt;
  logic                hs;
  logic [TAG_ID_W-1:0] gnt_id;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic                sel_op;
  tag_t                tag_p [LATENCY];

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .req  (req_valid_i),
    .en   (enable_i),
    .adv  (hs),
    .gnt  (gnt)
  );

  assign req_ready_o = gnt;
  assign hs          = |gnt;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = ADD;
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a_i[i*DATA_W +: DATA_W];
        sel_b  = req_b_i[i*DATA_W +: DATA_W];
        sel_op = req_addsub_i[i];
        gnt_id = TAG_ID_W'(i);
      end
    end
  end

  // issue stage: operands to the unit, tag enters stage 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fpu_a_o      <= '0;
      fpu_b_o      <= '0;
      fpu_addsub_o <= ADD;
      for (int i = 0; i < LATENCY; i++) tag_p[i] <= '0;
    end else begin
      if (hs) begin
        fpu_a_o      <= sel_a;
        fpu_b_o      <= sel_b;
        fpu_addsub_o <= sel_op;
      end
      tag_p[0] <= '{valid: hs, id: gnt_id};
      for (int i = 1; i < LATENCY; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  // response stage: tail tag qualifies the unit's result
  always_comb begin
    busy_o       = 1'b0;
    rsp_result_o = fpu_result_i;
    for (int i = 0; i < LATENCY; i++) busy_o = busy_o | tag_p[i].valid;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid_o[i] = tag_p[LATENCY-1].valid && (tag_p[LATENCY-1].id == TAG_ID_W'(i));
  end

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Bench for fp_addsub_sched: behavioural fp_addsub stand-in, scoreboard of issued ops, directed grant checks.
module tb_fp_addsub_sched;
  import fp_sched_pkg::*;

  localparam int NR  = 4;
  localparam int LAT = 3;
  localparam int DW  = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [NR-1:0]    req_valid, req_ready, req_addsub, rsp_valid;
  logic [NR*DW-1:0] req_a, req_b;
  logic             fpu_op;
  logic [DW-1:0]    fpu_a, fpu_b, fpu_result, rsp_result;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          id;
    logic [31:0] exp;
    int          cyc;
  } sb_t;
  sb_t sb_q[$];
  sb_t e;

  fp_addsub_sched #(.NUM_REQ(NR), .LATENCY(LAT), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addsub_i(req_addsub),
    .req_a_i(req_a), .req_b_i(req_b),
    .fpu_addsub_o(fpu_op), .fpu_a_o(fpu_a), .fpu_b_o(fpu_b), .fpu_result_i(fpu_result),
    .rsp_valid_o(rsp_valid), .rsp_result_o(rsp_result), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real sp2r(input logic [31:0] a);
    logic [10:0] e11;
    if (a[30:23] == 8'd0) return 0.0;
    e11 = {3'b0, a[30:23]} + 11'd896;
    return $bitstoreal({a[31], e11, a[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e11;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e11 = d[62:52] - 11'd896;
    return {d[63], e11[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    return (op == SUB) ? r2sp(sp2r(a) - sp2r(b)) : r2sp(sp2r(a) + sp2r(b));
  endfunction

  // stand-in unit: result reflects operands LAT-1 edges after they are registered
  logic [31:0] fpu_pipe [LAT-1];
  always @(posedge clk) begin
    fpu_pipe[0] <= fp_model(fpu_a, fpu_b, fpu_op);
    for (int i = 1; i < LAT-1; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign fpu_result = fpu_pipe[LAT-2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // scoreboard: responses popped first, then any handshake about to happen is pushed
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (rsp_valid != '0) begin
        if (sb_q.size() == 0) begin
          chk("unexp_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_id", 32'(rsp_valid), 32'(1) << e.id);
          chk("rsp_data", rsp_result, e.exp);
          chk("rsp_lat", 32'(cyc), 32'(e.cyc + LAT));
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i])
          sb_q.push_back('{id: i, cyc: cyc,
                           exp: fp_model(req_a[i*DW +: DW], req_b[i*DW +: DW], req_addsub[i])});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_addsub[i]     = op;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++)
      set_op(i, {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)},
                {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)},
                1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (LAT + 1) step();
    @(negedge clk);
    chk("drain_busy", 32'(busy), 32'd0);
    step();
  endtask

  task automatic single(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] res);
    set_op(r, a, b, op);
    req_valid = NR'(1) << r;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'(1) << r);
    step();
    req_valid = '0;
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      if (i == 0) chk("single_fpu_a", fpu_a, a);
      chk("single_busy", 32'(busy), (i < LAT) ? 32'd1 : 32'd0);
      chk("single_rsp_vld", 32'(rsp_valid), (i == LAT-1) ? (32'(1) << r) : 32'd0);
      if (i == LAT-1) chk("single_rsp_data", rsp_result, res);
    end
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] fair_exp [3];
    fair_exp[0] = 4'b1000; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b1000;

    rst_n = 1'b0; enable = 1'b1; req_valid = '0; req_addsub = '0; req_a = '0; req_b = '0;
    @(negedge clk);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_b", fpu_b, 32'd0);
    chk("rst_fpu_op", 32'(fpu_op), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    single(0, 32'h3F80_0000, 32'h4000_0000, ADD, 32'h4040_0000);
    single(2, 32'h40A0_0000, 32'h3F80_0000, SUB, 32'h4080_0000);

    // all four requesters streaming straight out of reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      @(negedge clk);
      chk("stream_ready", 32'(req_ready), 32'(1) << (k % NR));
      step();
    end
    drain();

    // fairness: move pointer to 2 via one grant to requester 1, then contend 1 vs 3
    req_valid = 4'b0010;
    rand_ops();
    @(negedge clk);
    chk("fair_setup", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      @(negedge clk);
      chk("fair_ready", 32'(req_ready), 32'(fair_exp[k]));
      step();
    end
    drain();

    // enable low with requests pending; in-flight work completes
    req_valid = '1;
    for (int k = 0; k < 2; k++) begin
      rand_ops();
      @(negedge clk);
      chk("en_pre_ready", 32'(req_ready), 32'(1) << k);
      step();
    end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("en_off_ready", 32'(req_ready), 32'd0);
      chk("en_off_busy", 32'(busy), (k < LAT) ? 32'd1 : 32'd0);
      step();
    end
    enable = 1'b1;
    rand_ops();
    @(negedge clk);
    chk("en_resume", 32'(req_ready), 32'h4);
    step();
    drain();

    // reset while operations are in flight
    req_valid = '1;
    for (int k = 0; k < 2; k++) begin
      rand_ops();
      @(negedge clk);
      chk("rst_pre_ready", 32'(req_ready), (k == 0) ? 32'h8 : 32'h1);
      step();
    end
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      step();
    end
    rst_n = 1'b1;
    req_valid = '0;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      step();
    end
    req_valid = 4'b1010;
    rand_ops();
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'h2);
    step();
    drain();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
